uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver: next generation of the single-format 8N1 receiver. It supports a configurable payload width, optional odd/even parity and one or two stop bits. Each bit is resolved by a 3-sample majority vote at the bit centre. The received word and its error flags are held in an output register with a valid/ready handshake and overrun detection. It sits between the board-level RX pin and the byte-stream consumers (command decoder, RX FIFO).

## Interface
- `BIT_RATE`, 9600: line bit rate in bits/s.
- `CLK_HZ`, 100000000: `clk` frequency in Hz. `CYCLES_PER_BIT = CLK_HZ/BIT_RATE` (integer division) must be ≥ 8.
- `PAYLOAD_BITS`, 8: data bits per frame, 5..8.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.

Ports:
- `clk` input 1: system clock. One clock domain only.
- `reset` input 1: synchronous, active-high reset.
- `uart_rxd` input 1: UART receive line, idle high.
- `recv_en` input 1: when low, no new frame start is accepted.
- `recv_valid` output 1: the holding register contains an unread frame.
- `recv_ready` input 1: consumer accepts the frame. A transfer occurs when `recv_valid && recv_ready` on a rising edge of `clk`.
- `recv_data` output PAYLOAD_BITS: received payload, LSB is the first bit received on the line.
- `parity_err` output 1: parity mismatch on the held frame. Always 0 when `PARITY`=0.
- `frame_err` output 1: at least one stop bit sampled low on the held frame.
- `break` output 1: the held frame is a break (all data, parity and stop samples low).
- `overrun` output 1: sticky flag. At least one frame was dropped because the holding register was full.

## Operation
- Bit counter width is `$clog2(CYCLES_PER_BIT)`. `MID = CYCLES_PER_BIT/2`.
- Bit value is the majority of the line samples taken at counter values MID-1, MID and MID+1.
- FSM states and transitions:
  - IDLE: on `uart_rxd`=0 with `recv_en`=1, clear the counter and go to START.
  - START: at counter MID+1, if the majority is 1 (false start), go to IDLE. Otherwise, at counter CYCLES_PER_BIT-1, clear the counter and go to DATA.
  - DATA: shift in PAYLOAD_BITS bits LSB-first, one per CYCLES_PER_BIT window. Then go to PARITY if `PARITY`≠0, otherwise to STOP.
  - PARITY: take one sample window. With odd parity, the XOR of the data and parity bits must be 1. With even parity, it must be 0.
  - STOP: take `STOP_BITS` sample windows. After the last stop-bit majority at MID+1, commit the frame and go to IDLE immediately (no wait for the end of the stop bit). If the frame is a break, go to BRK_WAIT instead.
  - BRK_WAIT: stay until `uart_rxd`=1 for 1 cycle, then go to IDLE.
- Commit rule:
  - If `recv_valid`=0, or `recv_ready`=1 in the same cycle: load data and flags, `recv_valid`<=1.
  - Otherwise: drop the frame, keep the old contents, `overrun`<=1.
- Handshake:
  - A transfer with no commit in the same cycle clears `recv_valid` and `overrun`.
  - `recv_data` and the flags stay stable while `recv_valid`=1 and are unchanged after the transfer.
- `recv_en` is sampled only in IDLE. Deasserting it mid-frame does not abort the current frame.
- Reset (any state): FSM→IDLE, counter and shift register cleared.

## Timing
- Reset values: `recv_valid`=0, `recv_data`=0, `parity_err`=0, `frame_err`=0, `break`=0, `overrun`=0.
- Latency: `recv_valid` rises on the cycle after the final stop-bit sample at counter MID+1. Without the synchroniser this is S + (1+PAYLOAD_BITS+P+STOP_BITS-1)·CYCLES_PER_BIT + MID + 2 cycles after the start edge reaches `uart_rxd`, where S is the start-edge cycle and P = (`PARITY`≠0).
- `UART_RX_SYNC_EN` adds 2 cycles to that latency.
- A back-to-back frame is accepted when its start edge arrives ≥1 cycle after the commit.
- Commit and transfer in the same cycle: the new frame is loaded and `recv_valid` stays 1 (no bubble).
- A glitch shorter than 2 cycles at the bit centre is rejected by the majority vote.

## Configuration
- `UART_RX_SYNC_EN` defined: `uart_rxd` passes through a 2-flop synchroniser, reset to 1, before all logic.
- `UART_RX_SYNC_EN` undefined: `uart_rxd` is used directly, and the caller guarantees it is synchronous to `clk`.

## Test plan
- All tests use CLK_HZ=50000000 and BIT_RATE=5000000 (10 cycles/bit).
- 8N1, byte 0xA5, `recv_ready`=1 → one-cycle `recv_valid` with `recv_data`=0xA5; all error flags 0.
- `PARITY`=2, 7-bit payload 0x55 sent with a wrong parity bit → `recv_data`=0x55, `parity_err`=1. Repeat with correct parity → `parity_err`=0.
- `STOP_BITS`=2, second stop bit low → `frame_err`=1, `break`=0. Then line held low for 30 bit times → exactly one frame with `break`=1, `frame_err`=1, `recv_data`=0. No further frame until the line goes high.
- `recv_ready`=0, frames 0x11 then 0x22 → `recv_data` stays 0x11, `overrun`=1. Assert `recv_ready` for 1 cycle → `recv_valid`=0, `overrun`=0.
- False start (low pulse of 3 cycles) → FSM returns to IDLE, no `recv_valid`. 1-cycle high glitch at a data-bit centre → bit value unchanged.
- Assert `reset` mid-DATA of frame 0x3C, release, send 0xC3 → only 0xC3 delivered, with all reset values correct during reset.

Source files
------------

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: receive-side holding-register bus (word, error flags, valid/ready).
// Revision: 1.0
`default_nettype none

interface uart_rx_cfg_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    recv_valid;
  logic                    recv_ready;
  logic [PAYLOAD_BITS-1:0] recv_data;
  logic                    parity_err;
  logic                    frame_err;
  logic                    break_flag;
  logic                    overrun;

  modport master (
    output recv_valid, recv_data, parity_err, frame_err, break_flag, overrun,
    input  recv_ready
  );

  modport slave (
    input  recv_valid, recv_data, parity_err, frame_err, break_flag, overrun,
    output recv_ready
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver, 3-sample majority vote, valid/ready holding register.
// Optional macro UART_RX_SYNC_EN inserts a 2-flop input synchroniser. Revision: 1.0
`default_nettype none

module uart_rx_cfg #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 100000000,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          uart_rxd,
  input  wire logic          recv_en,
  uart_rx_cfg_if.master      rx
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT);
  localparam int MID            = CYCLES_PER_BIT / 2;
  localparam int BIT_W          = 4;

  localparam logic [CNT_W-1:0] C_MID_M1 = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] C_MID    = CNT_W'(MID);
  localparam logic [CNT_W-1:0] C_MID_P1 = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [BIT_W-1:0] C_DLAST  = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [BIT_W-1:0] C_SLAST  = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4,
    S_BRK_WAIT = 3'd5
  } state_t;

  logic w_rxd;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;
  always_ff @(posedge clk) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], uart_rxd};
  end
  assign w_rxd = r_sync[1];
`else
  assign w_rxd = uart_rxd;
`endif

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [BIT_W-1:0]        r_bit, w_bit_nxt;
  logic [PAYLOAD_BITS-1:0] r_shift, w_shift_nxt;
  logic                    r_par, w_par_nxt;
  logic                    r_stop_err, w_stop_err_nxt;
  logic                    r_any_high, w_any_high_nxt;
  logic                    r_s0, r_s1;

  logic                    r_valid;
  logic [PAYLOAD_BITS-1:0] r_data;
  logic                    r_perr, r_ferr, r_brk, r_ovr;

  logic w_maj, w_at_vote, w_end_bit;
  logic w_commit, w_ferr_fin, w_brk_fin, w_perr_fin;

  // Third vote sample is the live line value at MID+1
  assign w_maj     = (r_s0 & r_s1) | (r_s0 & w_rxd) | (r_s1 & w_rxd);
  assign w_at_vote = (r_cnt == C_MID_P1);
  assign w_end_bit = (r_cnt == C_LAST);

  always_comb begin
    if (PARITY == 1)      w_perr_fin = ~(^r_shift ^ r_par);
    else if (PARITY == 2) w_perr_fin = ^r_shift ^ r_par;
    else                  w_perr_fin = 1'b0;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt + 1'b1;
    w_bit_nxt      = r_bit;
    w_shift_nxt    = r_shift;
    w_par_nxt      = r_par;
    w_stop_err_nxt = r_stop_err;
    w_any_high_nxt = r_any_high;
    w_commit       = 1'b0;
    w_ferr_fin     = r_stop_err | ~w_maj;
    w_brk_fin      = ~(r_any_high | w_maj);

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rxd && recv_en) begin
          w_state_nxt    = S_START;
          w_bit_nxt      = '0;
          w_stop_err_nxt = 1'b0;
          w_any_high_nxt = 1'b0;
        end
      end
      S_START: begin
        if (w_at_vote && w_maj) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_end_bit) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_at_vote) begin
          w_shift_nxt    = {w_maj, r_shift[PAYLOAD_BITS-1:1]};
          w_any_high_nxt = r_any_high | w_maj;
        end
        if (w_end_bit) begin
          w_cnt_nxt = '0;
          if (r_bit == C_DLAST) begin
            w_bit_nxt   = '0;
            w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_at_vote) begin
          w_par_nxt      = w_maj;
          w_any_high_nxt = r_any_high | w_maj;
        end
        if (w_end_bit) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        // Final stop bit commits at its centre so a back-to-back start is not missed
        if (w_at_vote) begin
          w_stop_err_nxt = w_ferr_fin;
          w_any_high_nxt = r_any_high | w_maj;
          if (r_bit == C_SLAST) begin
            w_commit    = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = w_brk_fin ? S_BRK_WAIT : S_IDLE;
          end
        end else if (w_end_bit) begin
          w_cnt_nxt = '0;
          w_bit_nxt = r_bit + 1'b1;
        end
      end
      S_BRK_WAIT: begin
        w_cnt_nxt = '0;
        if (w_rxd) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_stop_err <= 1'b0;
      r_any_high <= 1'b0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit      <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_par      <= w_par_nxt;
      r_stop_err <= w_stop_err_nxt;
      r_any_high <= w_any_high_nxt;
      if (r_cnt == C_MID_M1) r_s0 <= w_rxd;
      if (r_cnt == C_MID)    r_s1 <= w_rxd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_brk   <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_commit) begin
      if (!r_valid || rx.recv_ready) begin
        r_valid <= 1'b1;
        r_data  <= r_shift;
        r_perr  <= w_perr_fin;
        r_ferr  <= w_ferr_fin;
        r_brk   <= w_brk_fin;
      end else begin
        r_ovr <= 1'b1;
      end
    end else if (r_valid && rx.recv_ready) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign rx.recv_valid = r_valid;
  assign rx.recv_data  = r_data;
  assign rx.parity_err = r_perr;
  assign rx.frame_err  = r_ferr;
  assign rx.break_flag = r_brk;
  assign rx.overrun    = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed checks on three receiver builds (8N1, 7E1, 8N2) at 10 clocks per bit.
`default_nettype none

module tb_uart_rx_cfg;

  localparam int CPB = 10;
`ifdef UART_RX_SYNC_EN
  localparam int LAT_EXP = 100;
`else
  localparam int LAT_EXP = 98;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rxd = 3'b111;
  logic       en0 = 1'b1;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg_if #(.PAYLOAD_BITS(8)) if0 ();
  uart_rx_cfg_if #(.PAYLOAD_BITS(7)) if1 ();
  uart_rx_cfg_if #(.PAYLOAD_BITS(8)) if2 ();

  uart_rx_cfg #(.BIT_RATE(5000000), .CLK_HZ(50000000), .PAYLOAD_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut0 (.clk(clk), .reset(rst), .uart_rxd(rxd[0]), .recv_en(en0), .rx(if0.master));
  uart_rx_cfg #(.BIT_RATE(5000000), .CLK_HZ(50000000), .PAYLOAD_BITS(7), .PARITY(2), .STOP_BITS(1))
    dut1 (.clk(clk), .reset(rst), .uart_rxd(rxd[1]), .recv_en(1'b1), .rx(if1.master));
  uart_rx_cfg #(.BIT_RATE(5000000), .CLK_HZ(50000000), .PAYLOAD_BITS(8), .PARITY(0), .STOP_BITS(2))
    dut2 (.clk(clk), .reset(rst), .uart_rxd(rxd[2]), .recv_en(1'b1), .rx(if2.master));

  // Transfer monitor on the 8N1 build
  int         mon_cnt = 0;
  int         mon_cyc = 0;
  logic [7:0] mon_hist [0:31];
  logic [3:0] mon_flags = 4'h0;
  always @(negedge clk) begin
    if (if0.recv_valid && if0.recv_ready) begin
      mon_hist[mon_cnt[4:0]] <= if0.recv_data;
      mon_flags <= {if0.parity_err, if0.frame_err, if0.break_flag, if0.overrun};
      mon_cyc   <= cyc;
      mon_cnt   <= mon_cnt + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic drive(input int w, input logic v, input int n);
    @(negedge clk) rxd[w] = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_frame(input int w, input logic [7:0] d, input int nb, input int pmode,
                            input bit bad_par, input int sb, input bit last_stop,
                            input int gbit, output int t_start);
    logic p;
    @(negedge clk) rxd[w] = 1'b0;
    t_start = cyc;
    repeat (CPB - 1) @(negedge clk);
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      p = p ^ d[i];
      if (i == gbit) begin
        drive(w, d[i], 6);
        drive(w, ~d[i], 1);
        drive(w, d[i], 3);
      end else begin
        drive(w, d[i], CPB);
      end
    end
    if (pmode != 0) begin
      if (pmode == 1) p = ~p;
      drive(w, p ^ bad_par, CPB);
    end
    for (int s = 0; s < sb; s++)
      drive(w, (s == sb - 1) ? last_stop : 1'b1, CPB);
  endtask

  task automatic pulse_ready(input int w);
    @(negedge clk);
    if (w == 0) if0.recv_ready = 1'b1;
    else if (w == 1) if1.recv_ready = 1'b1;
    else if2.recv_ready = 1'b1;
    @(negedge clk);
    if0.recv_ready = 1'b0;
    if1.recv_ready = 1'b0;
    if2.recv_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++;
    if ({if0.recv_valid, if0.recv_data, if0.parity_err, if0.frame_err, if0.break_flag, if0.overrun} !== 13'h0) begin
      n_fail++; $display("FAIL reset_dut0: got %h, expected 0", {if0.recv_valid, if0.recv_data, if0.parity_err, if0.frame_err, if0.break_flag, if0.overrun});
    end
    n_tests++;
    if ({if1.recv_valid, if1.recv_data, if1.parity_err, if1.frame_err, if1.break_flag, if1.overrun} !== 12'h0) begin
      n_fail++; $display("FAIL reset_dut1: got %h, expected 0", {if1.recv_valid, if1.recv_data, if1.parity_err, if1.frame_err, if1.break_flag, if1.overrun});
    end
    n_tests++;
    if ({if2.recv_valid, if2.recv_data, if2.parity_err, if2.frame_err, if2.break_flag, if2.overrun} !== 13'h0) begin
      n_fail++; $display("FAIL reset_dut2: got %h, expected 0", {if2.recv_valid, if2.recv_data, if2.parity_err, if2.frame_err, if2.break_flag, if2.overrun});
    end
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    int c0, ts;
    c0 = mon_cnt;
    if0.recv_ready = 1'b1;
    send_frame(0, 8'hA5, 8, 0, 0, 1, 1'b1, -1, ts);
    drive(0, 1'b1, 20);
    n_tests++;
    if (mon_cnt !== c0 + 1) begin n_fail++; $display("FAIL basic_count: got %0d, expected %0d", mon_cnt - c0, 1); end
    n_tests++;
    if (mon_hist[c0[4:0]] !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h, expected a5", mon_hist[c0[4:0]]); end
    n_tests++;
    if (mon_flags !== 4'h0) begin n_fail++; $display("FAIL basic_flags: got %b, expected 0000", mon_flags); end
    n_tests++;
    if (mon_cyc - ts !== LAT_EXP) begin n_fail++; $display("FAIL basic_latency: got %0d, expected %0d", mon_cyc - ts, LAT_EXP); end
    n_tests++;
    if (if0.recv_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b, expected 0", if0.recv_valid); end
  endtask

  task automatic test_back_to_back();
    int c0, ts;
    c0 = mon_cnt;
    send_frame(0, 8'h5A, 8, 0, 0, 1, 1'b1, -1, ts);
    send_frame(0, 8'h96, 8, 0, 0, 1, 1'b1, -1, ts);
    drive(0, 1'b1, 20);
    n_tests++;
    if (mon_cnt !== c0 + 2) begin n_fail++; $display("FAIL b2b_count: got %0d, expected 2", mon_cnt - c0); end
    n_tests++;
    if ({mon_hist[c0[4:0]], mon_hist[c0[4:0] + 5'd1]} !== 16'h5A96) begin
      n_fail++; $display("FAIL b2b_data: got %h %h, expected 5a 96", mon_hist[c0[4:0]], mon_hist[c0[4:0] + 5'd1]);
    end
  endtask

  task automatic test_parity();
    int ts;
    if1.recv_ready = 1'b0;
    send_frame(1, 8'h55, 7, 2, 1, 1, 1'b1, -1, ts);
    drive(1, 1'b1, 20);
    n_tests++;
    if ({if1.recv_valid, if1.recv_data, if1.parity_err, if1.frame_err} !== {1'b1, 7'h55, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL parity_bad: got v=%b d=%h pe=%b fe=%b, expected v=1 d=55 pe=1 fe=0", if1.recv_valid, if1.recv_data, if1.parity_err, if1.frame_err);
    end
    pulse_ready(1);
    n_tests++;
    if (if1.recv_valid !== 1'b0) begin n_fail++; $display("FAIL parity_ack: got valid %b, expected 0", if1.recv_valid); end
    send_frame(1, 8'h55, 7, 2, 0, 1, 1'b1, -1, ts);
    drive(1, 1'b1, 20);
    n_tests++;
    if ({if1.recv_valid, if1.recv_data, if1.parity_err} !== {1'b1, 7'h55, 1'b0}) begin
      n_fail++; $display("FAIL parity_good: got v=%b d=%h pe=%b, expected v=1 d=55 pe=0", if1.recv_valid, if1.recv_data, if1.parity_err);
    end
    pulse_ready(1);
  endtask

  task automatic test_stop_break();
    int ts;
    if2.recv_ready = 1'b0;
    send_frame(2, 8'h81, 8, 0, 0, 2, 1'b0, -1, ts);
    drive(2, 1'b1, 30);
    n_tests++;
    if ({if2.recv_valid, if2.recv_data, if2.frame_err, if2.break_flag} !== {1'b1, 8'h81, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL stop2_low: got v=%b d=%h fe=%b brk=%b, expected v=1 d=81 fe=1 brk=0", if2.recv_valid, if2.recv_data, if2.frame_err, if2.break_flag);
    end
    pulse_ready(2);
    drive(2, 1'b0, 30 * CPB);
    n_tests++;
    if ({if2.recv_valid, if2.recv_data, if2.frame_err, if2.break_flag, if2.overrun} !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL break_frame: got v=%b d=%h fe=%b brk=%b ov=%b, expected v=1 d=00 fe=1 brk=1 ov=0", if2.recv_valid, if2.recv_data, if2.frame_err, if2.break_flag, if2.overrun);
    end
    pulse_ready(2);
    drive(2, 1'b0, 5 * CPB);
    n_tests++;
    if (if2.recv_valid !== 1'b0) begin n_fail++; $display("FAIL break_hold: got valid %b, expected 0", if2.recv_valid); end
    drive(2, 1'b1, 40);
    n_tests++;
    if (if2.recv_valid !== 1'b0) begin n_fail++; $display("FAIL break_release: got valid %b, expected 0", if2.recv_valid); end
  endtask

  task automatic test_overrun();
    int ts;
    if0.recv_ready = 1'b0;
    send_frame(0, 8'h11, 8, 0, 0, 1, 1'b1, -1, ts);
    drive(0, 1'b1, 20);
    send_frame(0, 8'h22, 8, 0, 0, 1, 1'b1, -1, ts);
    drive(0, 1'b1, 20);
    n_tests++;
    if ({if0.recv_valid, if0.recv_data, if0.overrun} !== {1'b1, 8'h11, 1'b1}) begin
      n_fail++; $display("FAIL overrun_hold: got v=%b d=%h ov=%b, expected v=1 d=11 ov=1", if0.recv_valid, if0.recv_data, if0.overrun);
    end
    pulse_ready(0);
    n_tests++;
    if ({if0.recv_valid, if0.overrun, if0.recv_data} !== {1'b0, 1'b0, 8'h11}) begin
      n_fail++; $display("FAIL overrun_clear: got v=%b ov=%b d=%h, expected v=0 ov=0 d=11", if0.recv_valid, if0.overrun, if0.recv_data);
    end
  endtask

  task automatic test_false_start_glitch();
    int c0, ts;
    if0.recv_ready = 1'b1;
    c0 = mon_cnt;
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 200);
    n_tests++;
    if (mon_cnt !== c0) begin n_fail++; $display("FAIL false_start: got %0d frames, expected 0", mon_cnt - c0); end
    send_frame(0, 8'hF0, 8, 0, 0, 1, 1'b1, 1, ts);
    drive(0, 1'b1, 20);
    n_tests++;
    if (mon_cnt !== c0 + 1 || mon_hist[c0[4:0]] !== 8'hF0) begin
      n_fail++; $display("FAIL glitch: got %0d frames data %h, expected 1 frame data f0", mon_cnt - c0, mon_hist[c0[4:0]]);
    end
  endtask

  task automatic test_recv_en();
    int c0, ts;
    c0 = mon_cnt;
    en0 = 1'b0;
    send_frame(0, 8'h77, 8, 0, 0, 1, 1'b1, -1, ts);
    drive(0, 1'b1, 20);
    en0 = 1'b1;
    n_tests++;
    if (mon_cnt !== c0) begin n_fail++; $display("FAIL recv_en_off: got %0d frames, expected 0", mon_cnt - c0); end
  endtask

  task automatic test_reset_mid();
    int c0, ts;
    c0 = mon_cnt;
    drive(0, 1'b0, CPB);
    drive(0, 1'b0, CPB);
    drive(0, 1'b0, CPB);
    drive(0, 1'b1, 5);
    @(negedge clk) rst = 1'b1;
    rxd[0] = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({if0.recv_valid, if0.recv_data, if0.parity_err, if0.frame_err, if0.break_flag, if0.overrun} !== 13'h0) begin
      n_fail++; $display("FAIL reset_mid_values: got %h, expected 0", {if0.recv_valid, if0.recv_data, if0.parity_err, if0.frame_err, if0.break_flag, if0.overrun});
    end
    @(negedge clk) rst = 1'b0;
    drive(0, 1'b1, 20);
    send_frame(0, 8'hC3, 8, 0, 0, 1, 1'b1, -1, ts);
    drive(0, 1'b1, 20);
    n_tests++;
    if (mon_cnt !== c0 + 1 || mon_hist[c0[4:0]] !== 8'hC3) begin
      n_fail++; $display("FAIL reset_mid_frame: got %0d frames data %h, expected 1 frame data c3", mon_cnt - c0, mon_hist[c0[4:0]]);
    end
  endtask

  initial begin
    if0.recv_ready = 1'b0;
    if1.recv_ready = 1'b0;
    if2.recv_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_parity();
    test_stop_break();
    test_overrun();
    test_false_start_glitch();
    test_recv_en();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
